// File: rtl/ethernet_frame_fifo.sv
// ethernet_frame_fifo
// Synchronous AXI4-Stream FIFO that buffers Ethernet frames behind the EFCC
// frame dropper. It drives fifo_is_almost_full back to the dropper, which
// samples it on the first beat of each frame. With FRAME_MODE=1 the FIFO
// holds a frame back until its tlast beat is stored (store-and-forward).
//
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   s_axis_*             write side: tdata, tkeep, tvalid, tready, tlast, tuser
//   m_axis_*             read side (first-word fall-through): same fields
//   fifo_is_almost_full  registered, high while occupancy > depth - margin
//   occupancy            number of stored beats, 0..2**DEPTH_LOG2
//   frame_count          number of stored tlast beats
module ethernet_frame_fifo #(
  parameter int C_AXIS_TDATA_WIDTH = 8,
  parameter int C_AXIS_TKEEP_WIDTH = C_AXIS_TDATA_WIDTH / 8,
  parameter int DEPTH_LOG2         = 12,
  parameter int ALMOST_FULL_MARGIN = 1536,
  parameter int FRAME_MODE         = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic                          s_axis_tuser,
  output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tuser,
  output logic                          fifo_is_almost_full,
  output logic [DEPTH_LOG2:0]           occupancy,
  output logic [DEPTH_LOG2:0]           frame_count
);

  localparam int DEPTH    = 2 ** DEPTH_LOG2;
  localparam int ENTRY_W  = C_AXIS_TDATA_WIDTH + C_AXIS_TKEEP_WIDTH + 2;
  localparam int AF_LIMIT = DEPTH - ALMOST_FULL_MARGIN;

  localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    headEntry;
  logic [DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
  logic [DEPTH_LOG2:0]   occ_q, occ_d;
  logic [DEPTH_LOG2:0]   frameCnt_q, frameCnt_d;
  logic                  outInFrame_q;
  logic                  almostFull_q;
  logic                  ready_q;
  logic                  full, empty, wrEn, rdEn;

  assign full  = (occ_q == FULL_CNT);
  assign empty = (occ_q == '0);

  // ready_q keeps tready low during reset and the edge that releases it.
  assign s_axis_tready = ready_q & ~full;
  assign wrEn          = s_axis_tvalid & s_axis_tready;
  assign rdEn          = m_axis_tvalid & m_axis_tready;

  // Head entry is read asynchronously so a beat is visible the cycle after
  // it is written; it only changes when the read pointer moves.
  assign headEntry = mem[rdPtr_q];
  assign {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = headEntry;

  generate
    if (FRAME_MODE != 0) begin : gStoreForward
      // Full term lets an oversized incomplete frame escape cut-through.
      assign m_axis_tvalid = ~empty & ((frameCnt_q != '0) | outInFrame_q | full);
    end else begin : gCutThrough
      assign m_axis_tvalid = ~empty;
    end
  endgenerate

  assign occupancy           = occ_q;
  assign frame_count         = frameCnt_q;
  assign fifo_is_almost_full = almostFull_q;

  always_comb begin
    occ_d      = occ_q;
    frameCnt_d = frameCnt_q;
    if (wrEn && !rdEn) occ_d = occ_q + CNT_ONE;
    if (rdEn && !wrEn) occ_d = occ_q - CNT_ONE;
    if ((wrEn && s_axis_tlast) && !(rdEn && m_axis_tlast)) frameCnt_d = frameCnt_q + CNT_ONE;
    if ((rdEn && m_axis_tlast) && !(wrEn && s_axis_tlast)) frameCnt_d = frameCnt_q - CNT_ONE;
  end

  // Storage carries no reset; stale contents are unreachable once the
  // pointers and occupancy are cleared.
  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr_q] <= {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      occ_q        <= '0;
      frameCnt_q   <= '0;
      outInFrame_q <= 1'b0;
      almostFull_q <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      ready_q      <= 1'b1;
      occ_q        <= occ_d;
      frameCnt_q   <= frameCnt_d;
      almostFull_q <= (int'(occ_d) > AF_LIMIT);
      if (wrEn) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (rdEn) begin
        rdPtr_q      <= rdPtr_q + PTR_ONE;
        outInFrame_q <= ~m_axis_tlast;
      end
    end
  end

endmodule

// File: tb/tb_ethernet_frame_fifo.sv
// Directed bench for ethernet_frame_fifo using three instances:
//   A: cut-through, depth 16, margin 4
//   B: store-and-forward, depth 128, margin 64
//   C: store-and-forward, depth 16, margin 4
module tb_ethernet_frame_fifo;

  logic clk = 1'b0;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // Instance A signals
  logic [7:0] aSData, aMData;
  logic       aSKeep, aSValid, aSReady, aSLast, aSUser;
  logic       aMKeep, aMValid, aMReady, aMLast, aMUser, aAf;
  logic [4:0] aOcc, aFc;

  // Instance B signals
  logic [7:0] bSData, bMData;
  logic       bSKeep, bSValid, bSReady, bSLast, bSUser;
  logic       bMKeep, bMValid, bMReady, bMLast, bMUser, bAf;
  logic [7:0] bOcc, bFc;

  // Instance C signals
  logic [7:0] cSData, cMData;
  logic       cSKeep, cSValid, cSReady, cSLast, cSUser;
  logic       cMKeep, cMValid, cMReady, cMLast, cMUser, cAf;
  logic [4:0] cOcc, cFc;

  ethernet_frame_fifo #(.C_AXIS_TDATA_WIDTH(8), .C_AXIS_TKEEP_WIDTH(1), .DEPTH_LOG2(4),
                        .ALMOST_FULL_MARGIN(4), .FRAME_MODE(0)) dutA (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(aSData), .s_axis_tkeep(aSKeep), .s_axis_tvalid(aSValid),
    .s_axis_tready(aSReady), .s_axis_tlast(aSLast), .s_axis_tuser(aSUser),
    .m_axis_tdata(aMData), .m_axis_tkeep(aMKeep), .m_axis_tvalid(aMValid),
    .m_axis_tready(aMReady), .m_axis_tlast(aMLast), .m_axis_tuser(aMUser),
    .fifo_is_almost_full(aAf), .occupancy(aOcc), .frame_count(aFc));

  ethernet_frame_fifo #(.C_AXIS_TDATA_WIDTH(8), .C_AXIS_TKEEP_WIDTH(1), .DEPTH_LOG2(7),
                        .ALMOST_FULL_MARGIN(64), .FRAME_MODE(1)) dutB (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(bSData), .s_axis_tkeep(bSKeep), .s_axis_tvalid(bSValid),
    .s_axis_tready(bSReady), .s_axis_tlast(bSLast), .s_axis_tuser(bSUser),
    .m_axis_tdata(bMData), .m_axis_tkeep(bMKeep), .m_axis_tvalid(bMValid),
    .m_axis_tready(bMReady), .m_axis_tlast(bMLast), .m_axis_tuser(bMUser),
    .fifo_is_almost_full(bAf), .occupancy(bOcc), .frame_count(bFc));

  ethernet_frame_fifo #(.C_AXIS_TDATA_WIDTH(8), .C_AXIS_TKEEP_WIDTH(1), .DEPTH_LOG2(4),
                        .ALMOST_FULL_MARGIN(4), .FRAME_MODE(1)) dutC (
    .clk(clk), .rstn(rstn),
    .s_axis_tdata(cSData), .s_axis_tkeep(cSKeep), .s_axis_tvalid(cSValid),
    .s_axis_tready(cSReady), .s_axis_tlast(cSLast), .s_axis_tuser(cSUser),
    .m_axis_tdata(cMData), .m_axis_tkeep(cMKeep), .m_axis_tvalid(cMValid),
    .m_axis_tready(cMReady), .m_axis_tlast(cMLast), .m_axis_tuser(cMUser),
    .fifo_is_almost_full(cAf), .occupancy(cOcc), .frame_count(cFc));

  // All tasks start and end 1 time unit after a rising edge.
  task automatic stepClk();
    @(posedge clk);
    #1;
  endtask

  task automatic aPush(input logic [7:0] d, input logic k, input logic l, input logic u);
    aSData = d; aSKeep = k; aSLast = l; aSUser = u; aSValid = 1'b1;
    stepClk();
    aSValid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) stepClk();
    total++; if (aMValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mvalid got=%b want=0", aMValid); end
    total++; if (aSReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_sready got=%b want=0", aSReady); end
    total++; if (aAf !== 1'b0) begin bad++; $display("[TB] FAIL reset_af got=%b want=0", aAf); end
    total++; if (aOcc !== 5'd0) begin bad++; $display("[TB] FAIL reset_occ got=%0d want=0", aOcc); end
    total++; if (bMValid !== 1'b0 || cMValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mvalid_bc got=%b%b want=00", bMValid, cMValid); end
    rstn = 1'b1;
    stepClk();
    total++; if (aSReady !== 1'b1) begin bad++; $display("[TB] FAIL post_reset_sready got=%b want=1", aSReady); end
  endtask

  task automatic test_single_beat();
    aMReady = 1'b1;
    aPush(8'hA5, 1'b1, 1'b1, 1'b0);
    total++; if (aMValid !== 1'b1) begin bad++; $display("[TB] FAIL single_mvalid got=%b want=1", aMValid); end
    total++; if (aMData !== 8'hA5) begin bad++; $display("[TB] FAIL single_data got=%h want=a5", aMData); end
    total++; if (aMLast !== 1'b1) begin bad++; $display("[TB] FAIL single_last got=%b want=1", aMLast); end
    total++; if (aFc !== 5'd1) begin bad++; $display("[TB] FAIL single_fc got=%0d want=1", aFc); end
    stepClk();
    total++; if (aOcc !== 5'd0) begin bad++; $display("[TB] FAIL single_occ_after got=%0d want=0", aOcc); end
    total++; if (aMValid !== 1'b0) begin bad++; $display("[TB] FAIL single_mvalid_after got=%b want=0", aMValid); end
    aMReady = 1'b0;
  endtask

  task automatic test_almost_full();
    aMReady = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      aPush(8'(8'h10 + i - 1), 1'b1, (i == 16), 1'b0);
      total++; if (aOcc !== 5'(i)) begin bad++; $display("[TB] FAIL af_occ beat=%0d got=%0d want=%0d", i, aOcc, i); end
      total++; if (aAf !== (i >= 13)) begin bad++; $display("[TB] FAIL af_flag beat=%0d got=%b want=%b", i, aAf, (i >= 13)); end
      total++; if (aSReady !== (i < 16)) begin bad++; $display("[TB] FAIL af_sready beat=%0d got=%b want=%b", i, aSReady, (i < 16)); end
    end
    aMReady = 1'b1;
    for (int i = 0; i < 16; i++) begin
      total++; if (aMData !== 8'(8'h10 + i)) begin bad++; $display("[TB] FAIL af_drain_data idx=%0d got=%h want=%h", i, aMData, 8'(8'h10 + i)); end
      stepClk();
    end
    total++; if (aOcc !== 5'd0 || aAf !== 1'b0) begin bad++; $display("[TB] FAIL af_drained got occ=%0d af=%b want occ=0 af=0", aOcc, aAf); end
    aMReady = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [10:0] q[$];
    logic [10:0] ent;
    int          lastCnt;
    aMReady = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ent = 11'($urandom);
      q.push_back(ent);
      aPush(ent[10:3], ent[2], ent[1], ent[0]);
    end
    total++; if (aOcc !== 5'd8) begin bad++; $display("[TB] FAIL b2b_fill_occ got=%0d want=8", aOcc); end
    aMReady = 1'b1;
    for (int c = 0; c < 100; c++) begin
      ent = 11'($urandom);
      {aSData, aSKeep, aSLast, aSUser} = ent;
      aSValid = 1'b1;
      total++; if ({aMData, aMKeep, aMLast, aMUser} !== q[0] || aMValid !== 1'b1) begin
        bad++; $display("[TB] FAIL b2b_head cyc=%0d got=%h v=%b want=%h", c, {aMData, aMKeep, aMLast, aMUser}, aMValid, q[0]);
      end
      stepClk();
      void'(q.pop_front());
      q.push_back(ent);
      lastCnt = 0;
      foreach (q[j]) if (q[j][1]) lastCnt++;
      total++; if (aOcc !== 5'd8) begin bad++; $display("[TB] FAIL b2b_occ cyc=%0d got=%0d want=8", c, aOcc); end
      total++; if (aFc !== 5'(lastCnt)) begin bad++; $display("[TB] FAIL b2b_fc cyc=%0d got=%0d want=%0d", c, aFc, lastCnt); end
    end
    aSValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      total++; if ({aMData, aMKeep, aMLast, aMUser} !== q[0]) begin
        bad++; $display("[TB] FAIL b2b_drain idx=%0d got=%h want=%h", i, {aMData, aMKeep, aMLast, aMUser}, q[0]);
      end
      void'(q.pop_front());
      stepClk();
    end
    total++; if (aOcc !== 5'd0 || aFc !== 5'd0) begin bad++; $display("[TB] FAIL b2b_end got occ=%0d fc=%0d want 0 0", aOcc, aFc); end
    aMReady = 1'b0;
  endtask

  task automatic test_store_forward();
    bMReady = 1'b1;
    bSKeep = 1'b1; bSUser = 1'b0;
    for (int i = 0; i < 64; i++) begin
      total++; if (bMValid !== 1'b0) begin bad++; $display("[TB] FAIL sf_early_mvalid beat=%0d got=%b want=0", i, bMValid); end
      bSData = 8'(i); bSLast = (i == 63); bSValid = 1'b1;
      stepClk();
    end
    bSValid = 1'b0;
    total++; if (bFc !== 8'd1) begin bad++; $display("[TB] FAIL sf_fc_full got=%0d want=1", bFc); end
    for (int i = 0; i < 64; i++) begin
      total++; if (bMValid !== 1'b1 || bMData !== 8'(i) || bMLast !== (i == 63)) begin
        bad++; $display("[TB] FAIL sf_egress idx=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b", i, bMValid, bMData, bMLast, 8'(i), (i == 63));
      end
      stepClk();
    end
    total++; if (bFc !== 8'd0 || bOcc !== 8'd0 || bMValid !== 1'b0) begin
      bad++; $display("[TB] FAIL sf_end got fc=%0d occ=%0d v=%b want 0 0 0", bFc, bOcc, bMValid);
    end
  endtask

  task automatic test_deadlock_escape();
    int  wrIdx = 0;
    int  rdIdx = 0;
    int  cyc   = 0;
    logic willWr, willRd;
    cMReady = 1'b1;
    cSKeep = 1'b1; cSUser = 1'b0;
    while (rdIdx < 20 && cyc < 200) begin
      cSValid = (wrIdx < 20);
      cSData  = 8'(8'h40 + wrIdx);
      cSLast  = (wrIdx == 19);
      total++; if (cOcc !== 5'(wrIdx - rdIdx)) begin bad++; $display("[TB] FAIL dl_occ cyc=%0d got=%0d want=%0d", cyc, cOcc, wrIdx - rdIdx); end
      total++; if (cSReady !== ((wrIdx - rdIdx) != 16)) begin bad++; $display("[TB] FAIL dl_sready cyc=%0d got=%b", cyc, cSReady); end
      if (rdIdx == 0) begin
        total++; if (cMValid !== (wrIdx == 16)) begin bad++; $display("[TB] FAIL dl_hold cyc=%0d got=%b want=%b", cyc, cMValid, (wrIdx == 16)); end
      end
      if (wrIdx == 16 && rdIdx == 0) begin
        total++; if (cFc !== 5'd0) begin bad++; $display("[TB] FAIL dl_fc_full got=%0d want=0", cFc); end
      end
      willWr = cSValid & cSReady;
      willRd = cMValid;
      if (willRd) begin
        total++; if (cMData !== 8'(8'h40 + rdIdx) || cMLast !== (rdIdx == 19)) begin
          bad++; $display("[TB] FAIL dl_data idx=%0d got=%h l=%b want=%h", rdIdx, cMData, cMLast, 8'(8'h40 + rdIdx));
        end
      end
      stepClk();
      if (willWr) wrIdx++;
      if (willRd) rdIdx++;
      cyc++;
    end
    cSValid = 1'b0;
    total++; if (rdIdx != 20) begin bad++; $display("[TB] FAIL dl_complete got=%0d beats want=20", rdIdx); end
    total++; if (cOcc !== 5'd0 || cFc !== 5'd0) begin bad++; $display("[TB] FAIL dl_end got occ=%0d fc=%0d want 0 0", cOcc, cFc); end
  endtask

  task automatic test_reset_mid_frame();
    aMReady = 1'b0;
    for (int i = 0; i < 5; i++) aPush(8'(8'h70 + i), 1'b1, 1'b0, 1'b0);
    total++; if (aOcc !== 5'd5 || aMValid !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre got occ=%0d v=%b want 5 1", aOcc, aMValid); end
    rstn = 1'b0;
    stepClk();
    total++; if (aOcc !== 5'd0) begin bad++; $display("[TB] FAIL mid_occ got=%0d want=0", aOcc); end
    total++; if (aFc !== 5'd0) begin bad++; $display("[TB] FAIL mid_fc got=%0d want=0", aFc); end
    total++; if (aMValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_mvalid got=%b want=0", aMValid); end
    rstn = 1'b1;
    stepClk();
    total++; if (aSReady !== 1'b1) begin bad++; $display("[TB] FAIL mid_sready got=%b want=1", aSReady); end
    for (int i = 0; i < 3; i++) aPush(8'(8'hC0 + i), 1'b1, (i == 2), (i == 1));
    total++; if (aOcc !== 5'd3 || aFc !== 5'd1) begin bad++; $display("[TB] FAIL mid_refill got occ=%0d fc=%0d want 3 1", aOcc, aFc); end
    aMReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total++; if (aMData !== 8'(8'hC0 + i) || aMLast !== (i == 2) || aMUser !== (i == 1)) begin
        bad++; $display("[TB] FAIL mid_egress idx=%0d got d=%h l=%b u=%b", i, aMData, aMLast, aMUser);
      end
      stepClk();
    end
    total++; if (aOcc !== 5'd0 || aFc !== 5'd0) begin bad++; $display("[TB] FAIL mid_end got occ=%0d fc=%0d want 0 0", aOcc, aFc); end
    aMReady = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    aSData = '0; aSKeep = 1'b0; aSValid = 1'b0; aSLast = 1'b0; aSUser = 1'b0; aMReady = 1'b0;
    bSData = '0; bSKeep = 1'b0; bSValid = 1'b0; bSLast = 1'b0; bSUser = 1'b0; bMReady = 1'b0;
    cSData = '0; cSKeep = 1'b0; cSValid = 1'b0; cSLast = 1'b0; cSUser = 1'b0; cMReady = 1'b0;
    test_reset();
    test_single_beat();
    test_almost_full();
    test_back_to_back();
    test_store_forward();
    test_deadlock_escape();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
